// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM elastic register: ctrl bit positions and state encoding.
package ex_mem_pkg;

  localparam int CTRL_W        = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGWRITE = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register of the EX/MEM stage; ctrl sits in the top CTRL_W bits so a kill
// turns the held bundle into a bubble without touching the rest of the payload.
module ex_mem_slot
  import ex_mem_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (kill)  q[W-1 -: CTRL_W] <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/ex_mem_elastic_reg.sv
// EX/MEM pipeline register with valid/ready, synchronous flush and a saturating stall counter.
// Defining EX_MEM_SKID_EN adds a skid slot so in_ready no longer depends on out_ready.
module ex_mem_elastic_reg
  import ex_mem_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_target,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_result,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   result;
    logic              zero;
    logic [XLEN-1:0]   data;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  state_t  state, state_nxt;
  bundle_t in_b, main_d, main_q;
  logic    accept, deliver, main_load, main_kill;

  assign in_b    = {in_ctrl, in_rd, in_target, in_result, in_zero, in_data};
  assign accept  = in_valid && in_ready && !flush;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = ST_EMPTY;
    else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
`ifdef EX_MEM_SKID_EN
          if (accept && !deliver) state_nxt = ST_TWO;
          else
`endif
          if (deliver && !accept) state_nxt = ST_EMPTY;
        end
`ifdef EX_MEM_SKID_EN
        ST_TWO:   if (deliver) state_nxt = ST_ONE;
`endif
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != ST_EMPTY);
`ifdef EX_MEM_SKID_EN
    in_ready  = (state != ST_TWO);
`else
    in_ready  = (state == ST_EMPTY) || out_ready;
`endif
    main_load = 1'b0;
    case (state)
      ST_EMPTY: main_load = accept;
      ST_ONE:   main_load = accept && deliver;
`ifdef EX_MEM_SKID_EN
      ST_TWO:   main_load = deliver;
`endif
      default:  main_load = 1'b0;
    endcase
    // Draining without a refill must leave a bubble (ctrl zero) behind.
    main_kill = flush || (deliver && !main_load);
  end

`ifdef EX_MEM_SKID_EN
  bundle_t skid_q;
  logic    skid_load, skid_kill;

  assign skid_load = (state == ST_ONE) && accept && !deliver;
  assign skid_kill = flush || ((state == ST_TWO) && deliver);
  assign main_d    = (state == ST_TWO) ? skid_q : in_b;

  ex_mem_slot #(.W(BW)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .kill(skid_kill), .d(in_b), .q(skid_q)
  );
`else
  assign main_d = in_b;
`endif

  ex_mem_slot #(.W(BW)) u_main (
    .clk(clk), .reset(reset), .load(main_load), .kill(main_kill), .d(main_d), .q(main_q)
  );

  assign out_ctrl   = main_q.ctrl;
  assign out_rd     = main_q.rd;
  assign out_target = main_q.target;
  assign out_result = main_q.result;
  assign out_zero   = main_q.zero;
  assign out_data   = main_q.data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       stall_cycles <= '0;
    else if (out_valid && !out_ready && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Scoreboard bench for ex_mem_elastic_reg: accepted bundles queue up, a negedge monitor
// compares handshake, payload and stall count against a queue-occupancy model.
module tb_ex_mem_elastic_reg;
  import ex_mem_pkg::*;

  localparam int XLEN  = 64;
  localparam int RD_W  = 5;
  localparam int CNT_W = 4;
`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, in_zero;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic [XLEN-1:0]   in_target, in_result, in_data;
  logic              out_valid, out_ready, out_zero;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;
  logic [XLEN-1:0]   out_target, out_result, out_data;
  logic [CNT_W-1:0]  stall_cycles;

  always #5 clk = ~clk;

  ex_mem_elastic_reg #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_rd(in_rd),
    .in_target(in_target), .in_result(in_result), .in_zero(in_zero), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_rd(out_rd),
    .out_target(out_target), .out_result(out_result), .out_zero(out_zero), .out_data(out_data),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   result;
    logic              zero;
    logic [XLEN-1:0]   data;
  } bund_t;

  bund_t exp_q[$];
  int    held = 0;   // bundles accepted and not yet delivered
  int    cnt  = 0;   // expected stall counter
  bit    acc_now = 1'b0;
  bit    mon_en  = 1'b0;
  int    n_tests = 0, n_fail = 0;

  function automatic bit exp_ready();
    if (SKID) return held < 2;
    return (held == 0) || out_ready;
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit fl, input bit ordy,
                       input logic [CTRL_W-1:0] ctrl, input logic [XLEN-1:0] res);
    @(posedge clk); #1;
    in_valid  = v;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = ctrl;
    in_rd     = RD_W'($urandom);
    in_target = {$urandom, $urandom};
    in_result = res;
    in_zero   = 1'($urandom);
    in_data   = {$urandom, $urandom};
    acc_now   = v && !fl && exp_ready();
    if (acc_now) exp_q.push_back({in_ctrl, in_rd, in_target, in_result, in_zero, in_data});
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("out_valid", out_valid, held > 0);
      check("in_ready", in_ready, exp_ready());
      check("stall_cycles", stall_cycles, cnt);
      if (held > 0)
        check("out_bundle", {out_ctrl, out_rd, out_target, out_result, out_zero, out_data}, exp_q[0]);
      else
        check("bubble_ctrl", out_ctrl, 0);
      if (held > 0 && !out_ready && cnt < (1 << CNT_W) - 1) cnt++;
      if (flush) begin
        for (int k = 0; k < held; k++) exp_q.delete(0);
        held = 0;
      end else begin
        if (held > 0 && out_ready) begin
          exp_q.delete(0);
          held--;
        end
        if (acc_now) held++;
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_rd = '0; in_target = '0; in_result = '0; in_zero = 1'b0; in_data = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall_cycles, 0);
    check("rst_payload", {out_ctrl, out_rd, out_target, out_result, out_zero, out_data}, 0);
    mon_en = 1'b1;
    @(negedge clk) reset = 1'b1;

    for (int i = 1; i <= 4; i++) drive(1, 0, 1, 5'b00001, 64'(i));
    repeat (2) drive(0, 0, 1, 5'b0, 64'd0);

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 5'b00011, 64'(10 + i));
    repeat (4) drive(0, 0, 1, 5'b0, 64'd0);

    repeat (2) drive(1, 0, 0, 5'b00101, 64'd20);
    drive(1, 1, 0, 5'b01001, 64'd99);
    repeat (2) drive(0, 0, 1, 5'b0, 64'd0);

    repeat (2) drive(0, 0, 1, 5'b11111, 64'd0);

    drive(1, 0, 0, 5'b00001, 64'd30);
    repeat (20) drive(0, 0, 0, 5'b0, 64'd0);
    repeat (3) drive(0, 0, 1, 5'b0, 64'd0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            CTRL_W'($urandom), {$urandom, $urandom});

    repeat (3) drive(1, 0, 0, 5'b10001, 64'd50);
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_payload", {out_ctrl, out_rd, out_target, out_result, out_zero, out_data}, 0);
    check("arst_stall", stall_cycles, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete(); held = 0; cnt = 0; acc_now = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) reset = 1'b1;
    mon_en = 1'b1;
    drive(1, 0, 1, 5'b00001, 64'd77);
    repeat (3) drive(0, 0, 1, 5'b0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

endmodule
